// File: rtl/debounce_timer.sv
// Settle timer for the debounce chain: waits COUNT_MAX cycles after the front end arms it, then latches sig_sync.
// Optional rise/fall strobes are enabled with `define DEBOUNCE_EDGE_PULSE_EN.
module debounce_timer #(
    parameter int unsigned COUNT_MAX   = 50000,
    parameter int unsigned CNT_W       = 16,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic state,
    input  logic sig_sync,
    output logic count_finished,
    output logic debounced,
    output logic rise_pulse,
    output logic fall_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fsm_t             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             deb_q, deb_d;
    logic             terminal;

    // An abort (state low) on the terminal-count cycle takes priority over completion.
    assign terminal = (fsm_q == COUNT) && state && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q  <= IDLE;
            cnt_q  <= '0;
            done_q <= 1'b0;
            deb_q  <= RESET_LEVEL;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            deb_q  <= deb_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (state) begin
                    fsm_d = COUNT;
                    cnt_d = '0;
                end
            end
            COUNT: begin
                if (!state) begin
                    fsm_d = IDLE;
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    fsm_d = DONE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // The front end still shows state=1 here and clears it on this edge.
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        done_d = terminal;
        deb_d  = terminal ? sig_sync : deb_q;
    end

    assign count_finished = done_q;
    assign debounced      = deb_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        rise_d = terminal && sig_sync && !deb_q;
        fall_d = terminal && !sig_sync && deb_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_timer.sv
// Scoreboard bench for debounce_timer with COUNT_MAX=4; expectations follow DEBOUNCE_EDGE_PULSE_EN.
module tb_debounce_timer;

    localparam int CM = 4;
`ifdef DEBOUNCE_EDGE_PULSE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk      = 1'b0;
    logic reset_n  = 1'b1;
    logic state    = 1'b0;
    logic sig_sync = 1'b0;
    logic count_finished, debounced, rise_pulse, fall_pulse;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int   due;
        logic deb;
        logic rise;
        logic fall;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mdl_deb = 1'b0;
    logic exp_deb = 1'b0;

    debounce_timer #(
        .COUNT_MAX  (CM),
        .CNT_W      (16),
        .RESET_LEVEL(1'b0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .state         (state),
        .sig_sync      (sig_sync),
        .count_finished(count_finished),
        .debounced     (debounced),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pops an expectation on every count_finished pulse; between pulses outputs must hold steady.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            exp_deb = 1'b0;
        end else if (count_finished) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_pulse cyc=%0d count_finished=1 required 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (cyc !== mon_e.due) begin
                    errors++;
                    $display("FAIL pulse_edge got edge %0d required edge %0d", cyc, mon_e.due);
                end
                checks++;
                if ({debounced, rise_pulse, fall_pulse} !== {mon_e.deb, mon_e.rise, mon_e.fall}) begin
                    errors++;
                    $display("FAIL pulse_outputs cyc=%0d deb/rise/fall=%b%b%b required %b%b%b", cyc,
                             debounced, rise_pulse, fall_pulse, mon_e.deb, mon_e.rise, mon_e.fall);
                end
                exp_deb = mon_e.deb;
            end
        end else begin
            checks++;
            if ({debounced, rise_pulse, fall_pulse} !== {exp_deb, 2'b00}) begin
                errors++;
                $display("FAIL steady_outputs cyc=%0d deb/rise/fall=%b%b%b required %b00", cyc,
                         debounced, rise_pulse, fall_pulse, exp_deb);
            end
            checks++;
            if (sb.size() > 0 && cyc > sb[0].due) begin
                errors++;
                $display("FAIL missing_pulse cyc=%0d count_finished=0 required 1 at edge %0d", cyc, sb[0].due);
                mon_e = sb.pop_front();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise state so the next edge samples it, and queue the expected settle result.
    task automatic arm(input logic sig);
        exp_t e;
        sig_sync = sig;
        state    = 1'b1;
        e.due    = cyc + 1 + CM;
        e.deb    = sig;
        e.rise   = EDGE_EN && sig && !mdl_deb;
        e.fall   = EDGE_EN && !sig && mdl_deb;
        mdl_deb  = sig;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({count_finished, debounced, rise_pulse, fall_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_values got %b required 0000",
                     {count_finished, debounced, rise_pulse, fall_pulse});
        end
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if ({count_finished, debounced, rise_pulse, fall_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release got %b required 0000",
                     {count_finished, debounced, rise_pulse, fall_pulse});
        end
    endtask

    task automatic test_clean_press();
        while (cyc < 9) tick();
        arm(1'b1);
        repeat (CM) tick();
        checks++;
        if (count_finished !== 1'b0 || debounced !== 1'b0) begin
            errors++;
            $display("FAIL press_early edge=%0d cf=%b deb=%b required 0 0", cyc, count_finished, debounced);
        end
        tick();
        checks++;
        if (cyc !== 14 || count_finished !== 1'b1 || rise_pulse !== EDGE_EN || debounced !== 1'b1) begin
            errors++;
            $display("FAIL press_edge14 edge=%0d cf=%b rise=%b deb=%b required edge 14 1 %b 1",
                     cyc, count_finished, rise_pulse, debounced, EDGE_EN);
        end
        tick();
        state = 1'b0;
        checks++;
        if (count_finished !== 1'b0 || rise_pulse !== 1'b0 || debounced !== 1'b1) begin
            errors++;
            $display("FAIL press_edge15 cf=%b rise=%b deb=%b required 0 0 1", count_finished, rise_pulse, debounced);
        end
        repeat (2) tick();
    endtask

    task automatic test_release();
        arm(1'b0);
        repeat (CM + 2) tick();
        state = 1'b0;
        repeat (2) tick();
        checks++;
        if (debounced !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL release deb=%b pending=%0d required 0 0", debounced, sb.size());
        end
    endtask

    task automatic test_bounce();
        arm(1'b0);
        sig_sync = 1'b1;
        tick();
        sig_sync = 1'b0;
        tick();
        sig_sync = 1'b1;
        tick();
        sig_sync = 1'b0;
        repeat (3) tick();
        state = 1'b0;
        repeat (2) tick();
        checks++;
        if (debounced !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL bounce deb=%b pending=%0d required 0 0", debounced, sb.size());
        end
    endtask

    task automatic test_abort();
        sig_sync = 1'b1;
        state    = 1'b1;
        repeat (3) tick();
        state = 1'b0;
        repeat (CM + 2) tick();
        checks++;
        if (debounced !== 1'b0) begin
            errors++;
            $display("FAIL abort_mid deb=%b required 0", debounced);
        end
        state = 1'b1;
        repeat (CM) tick();
        state = 1'b0;
        repeat (3) tick();
        checks++;
        if (debounced !== 1'b0) begin
            errors++;
            $display("FAIL abort_terminal deb=%b required 0", debounced);
        end
        arm(1'b1);
        repeat (CM + 2) tick();
        state = 1'b0;
        repeat (2) tick();
        checks++;
        if (debounced !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL abort_rearm deb=%b pending=%0d required 1 0", debounced, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        arm(1'b0);
        repeat (CM + 2) tick();
        arm(1'b1);
        repeat (CM + 2) tick();
        state = 1'b0;
        repeat (2) tick();
        checks++;
        if (debounced !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL back_to_back deb=%b pending=%0d required 1 0", debounced, sb.size());
        end
    endtask

    task automatic test_same_level();
        arm(1'b1);
        repeat (CM + 2) tick();
        state = 1'b0;
        repeat (2) tick();
        checks++;
        if (debounced !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL same_level deb=%b pending=%0d required 1 0", debounced, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        exp_t dropped;
        arm(1'b1);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({count_finished, debounced, rise_pulse, fall_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async got %b required 0000",
                     {count_finished, debounced, rise_pulse, fall_pulse});
        end
        dropped = sb.pop_back();
        mdl_deb = 1'b0;
        state   = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        arm(1'b1);
        repeat (CM + 2) tick();
        state = 1'b0;
        repeat (2) tick();
        checks++;
        if (debounced !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_rearm deb=%b pending=%0d required 1 0 (dropped due %0d)",
                     debounced, sb.size(), dropped.due);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_abort();
        test_back_to_back();
        test_same_level();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_timer.md
# debounce_timer

Back end of the switch/button debounce chain. It consumes the one-bit `state` flag raised by the debounce front end when the synchronizer reports a change. It times a fixed settle interval, then samples the synchronized input into the clean `debounced` output. It returns a one-cycle `count_finished` pulse that clears the front end's `state`, and can optionally emit single-cycle rise/fall strobes for downstream logic.

## Interface
- `COUNT_MAX`, default 50000, settle interval in clock cycles (1 ms at 50 MHz); legal range 2 to 2^CNT_W.
- `CNT_W`, default 16, counter width; must hold COUNT_MAX-1.
- `RESET_LEVEL`, default 1'b0, value loaded into `debounced` on reset.
- `clk`  input  1  system clock; all logic on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset. It acts on assertion regardless of `clk`. The top level drives it as the inverse of the front end's active-high `reset`.
- `state`  input  1  armed flag from the debounce front end; 1 = change pending.
- `sig_sync`  input  1  synchronized raw signal (synchronizer output, already metastability-safe).
- `count_finished`  output  1  registered one-cycle pulse; settle interval complete.
- `debounced`  output  1  registered clean level.
- `rise_pulse`  output  1  registered one-cycle strobe on a debounced 0→1 change.
- `fall_pulse`  output  1  registered one-cycle strobe on a debounced 1→0 change.

## Operation
- The FSM has 3 states, encoded in 2 bits: IDLE, COUNT and DONE. A `CNT_W`-bit counter `cnt` runs alongside it.
- IDLE
  - `state`=1 → go to COUNT, `cnt`←0.
  - Otherwise hold.
- COUNT
  - `state`=0 (abort): go to IDLE, `cnt`←0. Do not pulse `count_finished`; `debounced` is unchanged.
  - `cnt`==COUNT_MAX-1: go to DONE. Drive `count_finished`←1 and `debounced`←`sig_sync`. Raise the matching edge strobe if the level changed.
  - Otherwise `cnt`←`cnt`+1. The counter never wraps; the compare is on equality only.
- DONE
  - Lasts exactly one cycle, then goes to IDLE unconditionally.
  - `count_finished` and the strobes return to 0.
  - `state` is ignored here, because the front end still shows 1 during this cycle and clears it on this same edge.
- `sig_sync` is sampled only on the COUNT→DONE edge. Bounces inside the window are ignored.
- Same-level sample: if the sampled value equals `debounced`, `count_finished` still pulses and no strobe fires.
- Strobes: `rise_pulse`/`fall_pulse` are never both 1 and are only ever high in DONE.

## Timing
- Reset (`reset_n`=0) values:
  - FSM: IDLE.
  - `cnt`: 0.
  - `count_finished`, `rise_pulse`, `fall_pulse`: 0.
  - `debounced`: RESET_LEVEL.
- No strobe is generated by reset or by reset release.
- Latency: let k be the first edge at which `state`=1 is sampled in IDLE.
  - `count_finished`, the `debounced` update and the strobe all rise at edge k+COUNT_MAX.
  - They fall at edge k+COUNT_MAX+1.
- The front end clears `state` at edge k+COUNT_MAX+1. IDLE is re-entered on that same edge, so the timer cannot re-trigger spuriously.
- Minimum spacing between two `count_finished` pulses: COUNT_MAX+2 cycles.
- Reset mid-COUNT or mid-DONE: immediate return to the reset values. A pending update is discarded.
- If `state` drops on the terminal-count cycle, the abort wins: no pulse, no update.

## Configuration
- Macro: `DEBOUNCE_EDGE_PULSE_EN`.
- Defined: `rise_pulse`/`fall_pulse` are generated as described above.
- Undefined:
  - Both strobe outputs are tied to constant 0 and the strobe logic is removed.
  - Ports are kept so the instantiation does not change.
  - `count_finished` and `debounced` are unaffected.

## Test plan
All scenarios use COUNT_MAX=4, RESET_LEVEL=0 and the macro defined unless stated.
- Clean press: hold `sig_sync`=1, raise `state` so it is first sampled at edge 10 → `count_finished`=1 and `rise_pulse`=1 at edge 14 only; `debounced`=1 from edge 14.
- Bounce: hold `state`=1 while `sig_sync` toggles 1,0,1,0 during the window and ends at 0 → `debounced` stays 0, `count_finished` pulses once, no strobe.
- Release: with `debounced`=1, arm with `sig_sync`=0 → `fall_pulse` for one cycle at k+4; `debounced`=0.
- Abort: drop `state` after 2 counting cycles → no `count_finished`, FSM back in IDLE with `cnt`=0, `debounced` unchanged.
- Reset mid-operation: assert `reset_n`=0 while in COUNT with `cnt`=2 → all outputs 0 immediately, with no wait for a clock edge; the next arm restarts the full 4-cycle interval.
- Macro undefined: repeat the clean-press scenario → `rise_pulse` and `fall_pulse` stay 0 throughout; `count_finished` and `debounced` timing are identical to the first scenario.
